// File: rtl/fetch_queue_unit.sv
// -----------------------------------------------------------------------------
// fetch_queue_unit
//
// Instruction-fetch front end. Owns the fetch PC and issues one request at a
// time to instruction memory over a req/ack handshake that tolerates any ack
// latency, including zero-wait (ack in the same cycle as req). Returned
// instructions are queued together with their PCs in a DEPTH-entry in-order
// queue that decode drains through valid/ready. A redirect from execute
// flushes the queue and restarts fetch at the new target.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   imem_req/imem_addr   fetch request and address (address held until ack)
//   imem_ack/imem_rdata  memory response and returned instruction
//   redirect_valid/_pc   taken branch/jump pulse and its target
//   inst_valid/_ready    queue head handshake towards decode
//   inst_data/inst_pc    head instruction and its PC (0 when empty)
//   fifo_count           number of occupied queue entries
// -----------------------------------------------------------------------------
module fetch_queue_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4,
    parameter int                DEPTH    = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      imem_req,
    output logic [ADDR_W-1:0]         imem_addr,
    input  logic                      imem_ack,
    input  logic [INSTR_W-1:0]        imem_rdata,
    input  logic                      redirect_valid,
    input  logic [ADDR_W-1:0]         redirect_pc,
    output logic                      inst_valid,
    input  logic                      inst_ready,
    output logic [INSTR_W-1:0]        inst_data,
    output logic [ADDR_W-1:0]         inst_pc,
    output logic [$clog2(DEPTH):0]    fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    // Address of the request being thrown away; the bus must keep showing it
    // until the memory acks, while fetch_pc already holds the redirect target.
    logic [ADDR_W-1:0]  disc_addr_q, disc_addr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [INSTR_W-1:0] data_mem_q [DEPTH];
    logic [ADDR_W-1:0]  pc_mem_q   [DEPTH];

    logic push, pop, flush;

    // Redirect outranks everything: it suppresses both the push of a
    // same-cycle ack and any pending pop.
    assign flush = redirect_valid;
    assign push  = (state_q == S_REQ) && imem_ack && !redirect_valid;
    assign pop   = inst_valid && inst_ready && !redirect_valid;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        disc_addr_d = disc_addr_q;
        case (state_q)
            S_IDLE: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_pc;
                    state_d    = S_REQ;
                end else if (count_q < DEPTH_C) begin
                    // Registered count only: a pop this cycle is not credited.
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_pc;
                    if (!imem_ack) begin
                        disc_addr_d = fetch_pc_q;
                        state_d     = S_DISCARD;
                    end
                end else if (imem_ack) begin
                    fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
                    state_d    = (count_d < DEPTH_C) ? S_REQ : S_IDLE;
                end
            end
            S_DISCARD: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_pc;
                end else if (imem_ack) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage and the discard address carry no reset: they are only observed
    // through state that is itself reset.
    always_ff @(posedge clk) begin
        disc_addr_q <= disc_addr_d;
        if (push) begin
            data_mem_q[wr_ptr_q] <= imem_rdata;
            pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
        end
    end

    assign imem_req   = (state_q != S_IDLE);
    assign imem_addr  = (state_q == S_DISCARD) ? disc_addr_q : fetch_pc_q;
    assign inst_valid = (count_q != '0);
    assign inst_data  = inst_valid ? data_mem_q[rd_ptr_q] : '0;
    assign inst_pc    = inst_valid ? pc_mem_q[rd_ptr_q] : '0;
    assign fifo_count = count_q;

endmodule
